// File: rtl/sync_fork3.sv
// Three-way token fork: one upstream drive pulse is broadcast to three branches and
// o_free returns once all branches have freed. One-deep token buffer, sticky error flags, watchdog.
module sync_fork3 #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_drive,
  output logic o_free,
  output logic o_drive0,
  output logic o_drive1,
  output logic o_drive2,
  input  logic i_free0,
  input  logic i_free1,
  input  logic i_free2,
  output logic o_busy,
  output logic o_pending,
  output logic o_overflow,
  output logic o_proto_err,
  output logic o_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [CNT_W:0] TO = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_t           state, state_n;
  logic [2:0]       got, got_n, frees;
  logic             pend, pend_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             drive_n, free_n, ovf_n, perr_n, tmo_n, all_freed;

  always_comb begin
    frees     = {i_free2, i_free1, i_free0};
    all_freed = &(got | frees);
    state_n   = state;
    got_n     = got;
    pend_n    = pend;
    cnt_n     = cnt;
    drive_n   = 1'b0;
    free_n    = 1'b0;
    ovf_n     = o_overflow;
    perr_n    = o_proto_err;
    tmo_n     = o_timeout;
    case (state)
      IDLE: begin
        // frees in the launch cycle are errors too: counting starts next cycle
        if (|frees) perr_n = 1'b1;
        if (pend | i_drive) begin
          drive_n = 1'b1;
          got_n   = 3'b000;
          cnt_n   = '0;
          pend_n  = pend & i_drive;  // a new token alongside a buffered one is re-buffered
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (|(frees & got)) perr_n = 1'b1;
        got_n = got | frees;
        if (cnt != '1) cnt_n = cnt + CNT_W'(1);
        if (all_freed) begin
          free_n  = 1'b1;
          state_n = DONE;
        end else if (TO != '0 && ({1'b0, cnt} + (CNT_W+1)'(1)) >= TO) begin
          tmo_n = 1'b1;
        end
      end
      DONE: begin
        if (|frees) perr_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (state != IDLE && i_drive) begin
      if (pend) ovf_n  = 1'b1;
      else      pend_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      got         <= 3'b000;
      pend        <= 1'b0;
      cnt         <= '0;
      o_drive0    <= 1'b0;
      o_drive1    <= 1'b0;
      o_drive2    <= 1'b0;
      o_free      <= 1'b0;
      o_busy      <= 1'b0;
      o_pending   <= 1'b0;
      o_overflow  <= 1'b0;
      o_proto_err <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      state       <= state_n;
      got         <= got_n;
      pend        <= pend_n;
      cnt         <= cnt_n;
      o_drive0    <= drive_n;
      o_drive1    <= drive_n;
      o_drive2    <= drive_n;
      o_free      <= free_n;
      o_busy      <= (state_n != IDLE);
      o_pending   <= pend_n;
      o_overflow  <= ovf_n;
      o_proto_err <= perr_n;
      o_timeout   <= tmo_n;
    end
  end

endmodule

// File: tb/tb_sync_fork3.sv
// Directed-vector bench for sync_fork3; each scenario is a per-cycle table of
// inputs and hand-derived expected outputs.
module tb_sync_fork3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_drive = 1'b0, i_free0 = 1'b0, i_free1 = 1'b0, i_free2 = 1'b0;
  logic o_free, o_drive0, o_drive1, o_drive2;
  logic o_busy, o_pending, o_overflow, o_proto_err, o_timeout;
  logic [8:0] obs;

  int total = 0;
  int passed = 0;

  localparam logic [8:0] D = 9'b111_000000;
  localparam logic [8:0] F = 9'b000_100000;
  localparam logic [8:0] B = 9'b000_010000;
  localparam logic [8:0] P = 9'b000_001000;
  localparam logic [8:0] O = 9'b000_000100;
  localparam logic [8:0] E = 9'b000_000010;
  localparam logic [8:0] T = 9'b000_000001;

  sync_fork3 #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .o_free(o_free),
    .o_drive0(o_drive0), .o_drive1(o_drive1), .o_drive2(o_drive2),
    .i_free0(i_free0), .i_free1(i_free1), .i_free2(i_free2),
    .o_busy(o_busy), .o_pending(o_pending), .o_overflow(o_overflow),
    .o_proto_err(o_proto_err), .o_timeout(o_timeout)
  );

  assign obs = {o_drive0, o_drive1, o_drive2, o_free, o_busy, o_pending,
                o_overflow, o_proto_err, o_timeout};

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench at cycle 0, 1 time unit after the edge that follows release
  task automatic do_reset();
    i_drive = 1'b0;
    {i_free2, i_free1, i_free0} = 3'b000;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_drive = 1'b1;
    {i_free2, i_free1, i_free0} = 3'b111;
    step();
    step();
    total++;
    if (obs !== 9'b0) $display("FAIL reset_held got %b want %b", obs, 9'b0);
    else passed++;
    i_drive = 1'b0;
    {i_free2, i_free1, i_free0} = 3'b000;
    rst = 1'b0;
    step();
    total++;
    if (obs !== 9'b0) $display("FAIL reset_release got %b want %b", obs, 9'b0);
    else passed++;
  endtask

  task automatic test_basic();
    logic [8:0] ex [0:12];
    logic       dr [0:12];
    logic [2:0] fr [0:12];
    do_reset();
    for (int i = 0; i <= 12; i++) begin ex[i] = '0; dr[i] = 1'b0; fr[i] = '0; end
    dr[2] = 1'b1; fr[5] = 3'b001; fr[6] = 3'b100; fr[9] = 3'b010;
    ex[3] = D | B;
    for (int i = 4; i <= 9; i++) ex[i] = B;
    ex[10] = F | B;
    for (int c = 0; c <= 12; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL basic c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      i_drive = dr[c]; {i_free2, i_free1, i_free0} = fr[c];
      step();
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] ex [0:8];
    logic       dr [0:8];
    logic [2:0] fr [0:8];
    do_reset();
    for (int i = 0; i <= 8; i++) begin ex[i] = '0; dr[i] = 1'b0; fr[i] = '0; end
    dr[2] = 1'b1; fr[3] = 3'b111;
    ex[3] = D | B; ex[4] = F | B;
    for (int c = 0; c <= 8; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL simultaneous c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      i_drive = dr[c]; {i_free2, i_free1, i_free0} = fr[c];
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] ex [0:13];
    logic       dr [0:13];
    logic [2:0] fr [0:13];
    do_reset();
    for (int i = 0; i <= 13; i++) begin ex[i] = '0; dr[i] = 1'b0; fr[i] = '0; end
    dr[2] = 1'b1; dr[4] = 1'b1; dr[5] = 1'b1; fr[6] = 3'b111; fr[10] = 3'b111;
    ex[3] = D | B; ex[4] = B; ex[5] = B | P; ex[6] = B | P | O;
    ex[7] = F | B | P | O; ex[8] = P | O; ex[9] = D | B | O; ex[10] = B | O;
    ex[11] = F | B | O; ex[12] = O; ex[13] = O;
    for (int c = 0; c <= 13; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL back_to_back c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      i_drive = dr[c]; {i_free2, i_free1, i_free0} = fr[c];
      step();
    end
  endtask

  task automatic test_proto_idle();
    logic [8:0] ex [0:4];
    logic [2:0] fr [0:4];
    do_reset();
    for (int i = 0; i <= 4; i++) begin ex[i] = '0; fr[i] = '0; end
    fr[1] = 3'b010;
    ex[2] = E; ex[3] = E; ex[4] = E;
    for (int c = 0; c <= 4; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL proto_idle c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      i_drive = 1'b0; {i_free2, i_free1, i_free0} = fr[c];
      step();
    end
  endtask

  task automatic test_proto_dup();
    logic [8:0] ex [0:10];
    logic       dr [0:10];
    logic [2:0] fr [0:10];
    do_reset();
    for (int i = 0; i <= 10; i++) begin ex[i] = '0; dr[i] = 1'b0; fr[i] = '0; end
    dr[2] = 1'b1; fr[4] = 3'b001; fr[5] = 3'b001; fr[7] = 3'b110;
    ex[3] = D | B; ex[4] = B; ex[5] = B; ex[6] = B | E; ex[7] = B | E;
    ex[8] = F | B | E; ex[9] = E; ex[10] = E;
    for (int c = 0; c <= 10; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL proto_dup c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      i_drive = dr[c]; {i_free2, i_free1, i_free0} = fr[c];
      step();
    end
  endtask

  task automatic test_proto_launch();
    logic [8:0] ex [0:6];
    logic       dr [0:6];
    logic [2:0] fr [0:6];
    do_reset();
    for (int i = 0; i <= 6; i++) begin ex[i] = '0; dr[i] = 1'b0; fr[i] = '0; end
    dr[2] = 1'b1; fr[2] = 3'b111; fr[3] = 3'b111;
    ex[3] = D | B | E; ex[4] = F | B | E; ex[5] = E; ex[6] = E;
    for (int c = 0; c <= 6; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL proto_launch c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      i_drive = dr[c]; {i_free2, i_free1, i_free0} = fr[c];
      step();
    end
  endtask

  task automatic test_timeout();
    logic [8:0] ex [0:15];
    logic       dr [0:15];
    logic [2:0] fr [0:15];
    do_reset();
    for (int i = 0; i <= 15; i++) begin ex[i] = '0; dr[i] = 1'b0; fr[i] = '0; end
    dr[2] = 1'b1; fr[12] = 3'b111;
    ex[3] = D | B;
    for (int i = 4; i <= 10; i++) ex[i] = B;
    ex[11] = B | T; ex[12] = B | T; ex[13] = F | B | T; ex[14] = T; ex[15] = T;
    for (int c = 0; c <= 15; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL timeout c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      i_drive = dr[c]; {i_free2, i_free1, i_free0} = fr[c];
      step();
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] ex [0:5];
    logic       dr [0:5];
    logic [2:0] fr [0:5];
    do_reset();
    for (int i = 0; i <= 5; i++) begin ex[i] = '0; dr[i] = 1'b0; fr[i] = '0; end
    dr[2] = 1'b1; dr[3] = 1'b1; dr[4] = 1'b1; fr[3] = 3'b001; fr[4] = 3'b010;
    ex[3] = D | B; ex[4] = B | P; ex[5] = B | P | O;
    for (int c = 0; c <= 5; c++) begin
      total++;
      if (obs !== ex[c]) $display("FAIL async_pre c=%0d got %b want %b", c, obs, ex[c]);
      else passed++;
      if (c < 5) begin
        i_drive = dr[c]; {i_free2, i_free1, i_free0} = fr[c];
        step();
      end
    end
    i_drive = 1'b0; {i_free2, i_free1, i_free0} = 3'b000;
    #2 rst = 1'b1;
    #1;
    total++;
    if (obs !== 9'b0) $display("FAIL async_assert got %b want %b", obs, 9'b0);
    else passed++;
    #1 rst = 1'b0;
    step();
    total++;
    if (obs !== 9'b0) $display("FAIL async_idle got %b want %b", obs, 9'b0);
    else passed++;
    {i_free2, i_free1, i_free0} = 3'b100;
    step();
    {i_free2, i_free1, i_free0} = 3'b000;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (obs !== E) $display("FAIL async_stray_free c=%0d got %b want %b", c, obs, E);
      else passed++;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_back_to_back();
    test_proto_idle();
    test_proto_dup();
    test_proto_launch();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sync_fork3.md
Name: sync_fork3

Overview:
Clocked three-way fork, the split-side counterpart of the three-input wait-merge join. A single upstream drive pulse is broadcast as drive pulses to three downstream branches. The upstream free pulse is returned only after all three branches have freed, in any order. Adds a one-deep token buffer, protocol-error flags and a watchdog, for use where micropipeline tokens cross into synchronous logic.

Parameters:
TIMEOUT_CYCLES, 1023, WAIT cycles before o_timeout is set; 0 disables the watchdog.
CNT_W, 10, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
i_drive  input  1  upstream token, one-cycle pulse.
o_free  output  1  upstream acknowledge, one-cycle pulse.
o_drive0  output  1  branch 0 token, one-cycle pulse.
o_drive1  output  1  branch 1 token, one-cycle pulse.
o_drive2  output  1  branch 2 token, one-cycle pulse.
i_free0  input  1  branch 0 acknowledge, one-cycle pulse.
i_free1  input  1  branch 1 acknowledge, one-cycle pulse.
i_free2  input  1  branch 2 acknowledge, one-cycle pulse.
o_busy  output  1  high while in WAIT or DONE.
o_pending  output  1  high while a buffered token is held.
o_overflow  output  1  sticky: a token was dropped.
o_proto_err  output  1  sticky: a spurious or duplicate free was seen.
o_timeout  output  1  sticky: the watchdog expired.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high. It forces state IDLE, clears got[2:0], pend and the counter, and drives every output to 0. Reset mid-token discards the token; no o_free is issued after reset.
- All outputs are registered.
- State machine, IDLE:
  - Launch when (pend | i_drive) is 1 at cycle t.
  - Launch effect: o_drive0/1/2 are 1 for exactly cycle t+1; got is cleared; the counter is cleared; state becomes WAIT at t+1.
  - If the launch consumes pend, pend clears. If pend and i_drive are both 1, pend is consumed and i_drive is re-buffered, so pend stays 1.
- State machine, WAIT:
  - Each cycle, got[n] is set when i_freen is 1.
  - The all-freed condition uses (got | this cycle's frees), so frees may arrive simultaneously or in any order.
  - When the condition is met at cycle u: o_free is 1 for exactly cycle u+1, and state is DONE at u+1.
  - Minimum latency is i_drive at t, all frees at t+1, o_free at t+2.
- State machine, DONE: lasts one cycle, then goes to IDLE. A back-to-back token (pend set) therefore launches with drives at u+3.
- Buffering:
  - i_drive while not IDLE with pend=0 sets pend.
  - i_drive while not IDLE with pend=1 sets o_overflow; the token is dropped.
  - The same applies to i_drive in DONE.
- Protocol errors (o_proto_err set, event otherwise ignored):
  - any i_freen in IDLE or DONE;
  - i_freen in WAIT while got[n] is already 1;
  - i_freen in the launch cycle t, since frees are counted only from t+1.
- Watchdog:
  - The counter increments on each WAIT cycle and saturates.
  - When the counter reaches TIMEOUT_CYCLES with the all-freed condition still unmet, o_timeout is set.
  - The FSM stays in WAIT; there is no abort.
  - With TIMEOUT_CYCLES=0 the watchdog never fires.
- Sticky flags clear only on rst.
- o_drive0, o_drive1 and o_drive2 are always identical.

Test Plan:
- Reset release, i_drive at cycle 2 -> o_drive0/1/2 = 1 at cycle 3 only, o_busy = 1 from cycle 3. Frees 0@5, 2@6, 1@9 -> o_free = 1 at cycle 10 only, o_busy = 0 at cycle 11.
- i_drive@2, all three frees simultaneously @3 -> o_free@4; IDLE@5; no error flags.
- i_drive@2, second i_drive@4 -> o_pending = 1 @5. All frees @6 -> o_free@7, second drive burst @9. A third i_drive@5 during the first token -> o_overflow = 1 @6.
- i_free1 pulsed in IDLE -> o_proto_err = 1 next cycle. After reset, i_drive@2, i_free0@4 and @5 -> o_proto_err = 1 @6; o_free still requires free1 and free2.
- TIMEOUT_CYCLES = 8, i_drive@2, no frees -> o_timeout = 1 after the 8th WAIT cycle. Later all frees -> o_free still pulses; o_timeout remains 1.
- rst asserted asynchronously mid-WAIT with got = 3'b011 -> all outputs 0 immediately. After release, i_free2 -> o_proto_err = 1 and no o_free.
